hud_digit_row: RTL and testbench
================================

Name: hud_digit_row

Overview:
- Parametrised HUD numeric overlay: renders a row of NUM_DIGITS seven-segment digits at a fixed screen position, as one colour layer for the VGA pixel mux.
- Digits are written one at a time (direct mode) or loaded from a binary value via an internal sequential double-dabble converter (binary mode).
- Successor to the fixed 14-digit red-only overlay: generalised count, geometry and colour, adds binary-to-BCD conversion, overflow saturation and a valid/ready write handshake.

Parameters:
- NUM_DIGITS, 4, digits in row (1..14); digit 0 is leftmost and most significant
- VALUE_W, 14, binary-mode input width (1..32)
- X0, 0, left edge of digit 0 (pixels)
- Y0, 715, top edge of row (lines)
- DIGIT_W, 20, cell width in pixels
- DIGIT_H, 40, cell height in lines (even)
- PITCH, 25, horizontal spacing between digit left edges (>= DIGIT_W)
- SEG_T, 4, segment thickness in pixels (2*SEG_T < DIGIT_W, 3*SEG_T < DIGIT_H)
- COLOR, 24'hFF0000, RGB of lit segments

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  11  current pixel column
- vcount  in  10  current pixel line
- wr_valid  in  1  write request
- wr_ready  out  1  block can accept a write
- wr_mode  in  1  0 = direct digit write, 1 = binary value load
- wr_index  in  4  target digit (direct mode)
- wr_digit  in  4  digit code (direct mode)
- wr_value  in  VALUE_W  binary value (binary mode)
- overflow  out  1  one-cycle pulse: binary value saturated
- in_hud  out  1  pixel lies on a lit segment (aligned with pixel)
- pixel  out  24  COLOR when in_hud, else 24'h0

Behaviour:
- Reset: all digit registers = 4'hF (blank); wr_ready=1; overflow=0; pixel=0; in_hud=0; FSM to IDLE. Reset mid-conversion aborts; no partial result committed.
- Write accepted on clk edge with wr_valid && wr_ready.
- Direct mode: digit[wr_index] <= wr_digit next edge; wr_ready stays 1. wr_index >= NUM_DIGITS: write dropped, no other effect.
- Digit codes: 0-9 glyph; 4'hE dash (segment g only); any other code blank.
- Binary mode FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - Accept: latch wr_value, clear BCD scratch, wr_ready <= 0, go SHIFT.
  - SHIFT: exactly VALUE_W cycles; each cycle add 3 to every BCD nibble >= 5, then shift left one bit, taking the next value MSB.
  - COMMIT (1 cycle): if latched value >= 10^NUM_DIGITS, all digits <= 9 and overflow pulses 1 cycle; otherwise digits <= low NUM_DIGITS BCD nibbles, most significant to digit 0. wr_ready <= 1 on the following edge.
  - Accept to wr_ready high = VALUE_W+2 cycles. Writes while wr_ready=0 are ignored (no queueing).
  - Digit registers change only in COMMIT, so display never shows a partial result.
- Geometry: digit i cell spans x in [X0+i*PITCH, X0+i*PITCH+DIGIT_W), y in [Y0, Y0+DIGIT_H). Local (lx,ly); M=(DIGIT_H-SEG_T)/2.
  - a: ly<SEG_T, SEG_T<=lx<DIGIT_W-SEG_T
  - g: M<=ly<M+SEG_T, same lx span
  - d: ly>=DIGIT_H-SEG_T, same lx span
  - f/b: lx<SEG_T / lx>=DIGIT_W-SEG_T, SEG_T<=ly<M+SEG_T
  - e/c: lx<SEG_T / lx>=DIGIT_W-SEG_T, M<=ly<DIGIT_H-SEG_T
  - Standard segment sets per digit 0-9. Pixels between cells (gap PITCH-DIGIT_W) are never lit.
- Pixel pipeline: fixed 2-cycle latency from hcount/vcount to pixel/in_hud.
  - Stage 1 registers cell hit, digit index and local coords.
  - Stage 2 registers segment decode and colour.
  - Digit register updates take effect on pixels sampled after the update edge.
- Arithmetic: all coordinate compares unsigned 12-bit; no wrap-around support (row must lie fully on screen).

Optional Feature:
- Macro HUD_LZ_BLANK_EN.
  - Defined: leading-zero blanking applied at render. Any digit 0 whose every more-significant digit is 0 or blank renders blank; the rightmost digit always renders. Applies to both write modes; stored registers are unchanged.
  - Undefined: digits render exactly as stored.

Test Plan:
- Reset, scan frame -> pixel=0 everywhere, in_hud never 1, wr_ready=1.
- Binary load 1234 (NUM_DIGITS=4, VALUE_W=14) -> wr_ready low 16 cycles; digits 1,2,3,4; pixel at digit 0 local (lx=18, ly=10) = 24'hFF0000 two cycles after hcount/vcount, and at (lx=1, ly=10) = 0 (digit 1 lacks f).
- Binary load 12000 -> overflow pulse exactly 1 cycle at COMMIT; digits 9,9,9,9.
- Direct writes index 2 code 4'hE and index 9 code 5 -> digit 2 shows segment g only; index 9 dropped, others unchanged; wr_ready stays 1.
- Assert wr_valid mid-conversion, then reset mid-conversion -> extra write ignored; after reset all digits blank, wr_ready=1, no overflow.
- HUD_LZ_BLANK_EN defined, binary load 7 -> only digit 3 lit ("7"); undefined -> "0007" rendered.

Source files
------------

// File: rtl/hud_digit_row.sv
// HUD numeric overlay: a row of seven-segment digits rendered as one colour layer,
// written per digit or loaded from binary via double-dabble. Optional macro HUD_LZ_BLANK_EN.
module hud_digit_row #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VALUE_W    = 14,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 715,
    parameter int unsigned DIGIT_W    = 20,
    parameter int unsigned DIGIT_H    = 40,
    parameter int unsigned PITCH      = 25,
    parameter int unsigned SEG_T      = 4,
    parameter logic [23:0] COLOR      = 24'hFF0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_mode,
    input  logic [3:0]         wr_index,
    input  logic [3:0]         wr_digit,
    input  logic [VALUE_W-1:0] wr_value,
    output logic               overflow,
    output logic               in_hud,
    output logic [23:0]        pixel
);

    localparam int unsigned BCD_MIN = (VALUE_W + 2) / 3;
    localparam int unsigned BCD_N   = (NUM_DIGITS > BCD_MIN) ? NUM_DIGITS : BCD_MIN;
    localparam int unsigned BCD_W   = 4 * BCD_N;
    localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
    localparam int unsigned MID     = (DIGIT_H - SEG_T) / 2;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CW      = 12;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         digit_q   [NUM_DIGITS];
    logic [3:0]         digit_eff [NUM_DIGITS];
    logic [VALUE_W-1:0] value_q;
    logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept, acc_bin, acc_dir, over_c;

    assign accept  = wr_valid && wr_ready;
    assign acc_bin = accept && wr_mode;
    assign acc_dir = accept && !wr_mode;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_bin) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble step, plus overflow = any BCD nibble above the displayed ones.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], value_q[VALUE_W-1]};
        over_c = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) over_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ready <= 1'b1;
            overflow <= 1'b0;
            value_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'hF;
        end else begin
            overflow <= 1'b0;
            if (acc_bin) begin
                value_q  <= wr_value;
                bcd_q    <= '0;
                cnt_q    <= '0;
                wr_ready <= 1'b0;
            end else if (state_q == IDLE) begin
                wr_ready <= 1'b1;
            end
            if (acc_dir) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_index == IDX_W'(i)) digit_q[i] <= wr_digit;
                end
            end
            if (state_q == SHIFT) begin
                bcd_q   <= bcd_next;
                value_q <= value_q << 1;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (state_q == COMMIT) begin
                overflow <= over_c;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    digit_q[i] <= over_c ? 4'd9 : bcd_q[4*(NUM_DIGITS-1-i) +: 4];
                end
            end
        end
    end

`ifdef HUD_LZ_BLANK_EN
    // Blank zeros that only have zero/blank digits to their left; rightmost always shows.
    always_comb begin
        logic lead;
        lead = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit_eff[i] = digit_q[i];
            if (lead && (digit_q[i] == 4'd0) && (i != NUM_DIGITS - 1)) digit_eff[i] = 4'hF;
            lead = lead && ((digit_q[i] == 4'd0) ||
                            ((digit_q[i] > 4'd9) && (digit_q[i] != 4'hE)));
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_eff[i] = digit_q[i];
    end
`endif

    // Stage 1: locate the cell under the current pixel.
    logic [CW-1:0]    hx, vy, lx_c, lx_s1, ly_s1;
    logic [IDX_W-1:0] idx_c, idx_s1;
    logic             hit_c, row_c, hit_s1;

    always_comb begin
        hx    = CW'(hcount);
        vy    = CW'(vcount);
        row_c = (vy >= CW'(Y0)) && (vy < CW'(Y0 + DIGIT_H));
        hit_c = 1'b0;
        idx_c = '0;
        lx_c  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((hx >= CW'(X0 + i*PITCH)) && (hx < CW'(X0 + i*PITCH + DIGIT_W))) begin
                hit_c = row_c;
                idx_c = IDX_W'(i);
                lx_c  = hx - CW'(X0 + i*PITCH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s1 <= 1'b0;
            idx_s1 <= '0;
            lx_s1  <= '0;
            ly_s1  <= '0;
        end else begin
            hit_s1 <= hit_c;
            idx_s1 <= idx_c;
            lx_s1  <= lx_c;
            ly_s1  <= vy - CW'(Y0);
        end
    end

    // Segment set {g,f,e,d,c,b,a} for a digit code.
    function automatic logic [6:0] seg_mask(input logic [3:0] code);
        case (code)
            4'd0:    seg_mask = 7'h3F;
            4'd1:    seg_mask = 7'h06;
            4'd2:    seg_mask = 7'h5B;
            4'd3:    seg_mask = 7'h4F;
            4'd4:    seg_mask = 7'h66;
            4'd5:    seg_mask = 7'h6D;
            4'd6:    seg_mask = 7'h7D;
            4'd7:    seg_mask = 7'h07;
            4'd8:    seg_mask = 7'h7F;
            4'd9:    seg_mask = 7'h6F;
            4'hE:    seg_mask = 7'h40;
            default: seg_mask = 7'h00;
        endcase
    endfunction

    // Stage 2: segment geometry against the selected digit.
    logic [3:0] code_c;
    logic [6:0] region_c;
    logic       hspan_c, left_c, right_c, lit_c;

    always_comb begin
        code_c = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_s1 == IDX_W'(i)) code_c = digit_eff[i];
        end
        hspan_c = (lx_s1 >= CW'(SEG_T)) && (lx_s1 < CW'(DIGIT_W - SEG_T));
        left_c  = lx_s1 < CW'(SEG_T);
        right_c = lx_s1 >= CW'(DIGIT_W - SEG_T);
        region_c[0] = hspan_c && (ly_s1 < CW'(SEG_T));
        region_c[1] = right_c && (ly_s1 >= CW'(SEG_T)) && (ly_s1 < CW'(MID + SEG_T));
        region_c[2] = right_c && (ly_s1 >= CW'(MID)) && (ly_s1 < CW'(DIGIT_H - SEG_T));
        region_c[3] = hspan_c && (ly_s1 >= CW'(DIGIT_H - SEG_T));
        region_c[4] = left_c && (ly_s1 >= CW'(MID)) && (ly_s1 < CW'(DIGIT_H - SEG_T));
        region_c[5] = left_c && (ly_s1 >= CW'(SEG_T)) && (ly_s1 < CW'(MID + SEG_T));
        region_c[6] = hspan_c && (ly_s1 >= CW'(MID)) && (ly_s1 < CW'(MID + SEG_T));
        lit_c = hit_s1 && (|(seg_mask(code_c) & region_c));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_hud <= 1'b0;
            pixel  <= 24'h0;
        end else begin
            in_hud <= lit_c;
            pixel  <= lit_c ? COLOR : 24'h0;
        end
    end

endmodule

// File: tb/tb_hud_digit_row.sv
// Randomized self-checking bench for hud_digit_row against a decimal/geometry reference model.
module tb_hud_digit_row;

    localparam int N   = 4;
    localparam int VW  = 14;
    localparam int X0  = 0;
    localparam int Y0  = 715;
    localparam int DW  = 20;
    localparam int DH  = 40;
    localparam int P   = 25;
    localparam int T   = 4;
    localparam int M   = (DH - T) / 2;
    localparam logic [23:0] COL = 24'hFF0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          wr_valid, wr_ready, wr_mode, overflow, in_hud;
    logic [3:0]    wr_index, wr_digit;
    logic [VW-1:0] wr_value;
    logic [23:0]   pixel;

    hud_digit_row #(
        .NUM_DIGITS(N), .VALUE_W(VW), .X0(X0), .Y0(Y0), .DIGIT_W(DW),
        .DIGIT_H(DH), .PITCH(P), .SEG_T(T), .COLOR(COL)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
        .wr_index(wr_index), .wr_digit(wr_digit), .wr_value(wr_value),
        .overflow(overflow), .in_hud(in_hud), .pixel(pixel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int md [N];
    string glyphs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_seg(input string s, input byte c);
        for (int k = 0; k < s.len(); k++) if (s[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int eff(input int i);
`ifdef HUD_LZ_BLANK_EN
        bit all_lead = 1'b1;
        for (int j = 0; j < i; j++)
            if (!(md[j] == 0 || (md[j] > 9 && md[j] != 14))) all_lead = 1'b0;
        if (md[i] == 0 && all_lead && i != N - 1) return 15;
`endif
        return md[i];
    endfunction

    function automatic logic [23:0] model_px(input int h, input int v);
        int dx, i, lx, ly, c;
        string s;
        bit hs, l, r, lit;
        if (v < Y0 || v >= Y0 + DH || h < X0) return 24'h0;
        dx = h - X0;
        i  = dx / P;
        lx = dx % P;
        ly = v - Y0;
        if (i >= N || lx >= DW) return 24'h0;
        c = eff(i);
        if (c <= 9) s = glyphs[c];
        else if (c == 14) s = "g";
        else s = "";
        hs = (lx >= T) && (lx < DW - T);
        l  = lx < T;
        r  = lx >= DW - T;
        lit = (has_seg(s, "a") && hs && ly < T) ||
              (has_seg(s, "g") && hs && ly >= M && ly < M + T) ||
              (has_seg(s, "d") && hs && ly >= DH - T) ||
              (has_seg(s, "f") && l && ly >= T && ly < M + T) ||
              (has_seg(s, "b") && r && ly >= T && ly < M + T) ||
              (has_seg(s, "e") && l && ly >= M && ly < DH - T) ||
              (has_seg(s, "c") && r && ly >= M && ly < DH - T);
        return lit ? COL : 24'h0;
    endfunction

    // Random coordinates streamed one per cycle, each checked two cycles later.
    task automatic scan(input int npts, input bit full);
        logic [23:0] exp_q [$];
        logic [23:0] e;
        int h, v;
        for (int k = 0; k < npts + 2; k++) begin
            @(posedge clk); #1;
            if (k >= 2) begin
                e = exp_q.pop_front();
                chk("pixel", 64'(pixel), 64'(e));
                chk("in_hud", 64'(in_hud), 64'(e != 24'h0));
            end
            if (k < npts) begin
                if (full) begin
                    h = int'($urandom_range(0, 2047));
                    v = int'($urandom_range(0, 1023));
                end else begin
                    h = int'($urandom_range(0, X0 + N*P + 4));
                    v = int'($urandom_range(Y0 - 4, Y0 + DH + 4));
                end
                hcount = 11'(h);
                vcount = 10'(v);
                exp_q.push_back(model_px(h, v));
            end
        end
    endtask

    task automatic probe(input string tag, input int h, input int v, input logic [23:0] exp);
        @(posedge clk); #1;
        hcount = 11'(h);
        vcount = 10'(v);
        repeat (2) @(posedge clk);
        #1;
        chk(tag, 64'(pixel), 64'(exp));
    endtask

    task automatic wait_ready(output int low, output int ov);
        low = 0;
        ov  = 0;
        while (!wr_ready && low < 100) begin
            @(posedge clk); #1;
            low++;
            if (overflow) ov++;
        end
    endtask

    task automatic model_bin(input int val);
        int x = val;
        if (val >= 10 ** N) begin
            for (int i = 0; i < N; i++) md[i] = 9;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                md[i] = x % 10;
                x = x / 10;
            end
        end
    endtask

    task automatic bin_load(input int val);
        int low, ov;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_mode  = 1'b1;
        wr_value = VW'(val);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_ready(low, ov);
        chk("ready_low_cycles", 64'(low), 64'(VW + 2));
        chk("overflow_cycles", 64'(ov), 64'(val >= 10 ** N));
        model_bin(val);
    endtask

    task automatic dwrite(input int idx, input int code);
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_mode  = 1'b0;
        wr_index = 4'(idx);
        wr_digit = 4'(code);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("ready_direct", 64'(wr_ready), 64'd1);
        if (idx < N) md[idx] = code;
    endtask

    initial begin
        int low, ov;
        reset = 1'b1; hcount = '0; vcount = '0;
        wr_valid = 1'b0; wr_mode = 1'b0; wr_index = '0; wr_digit = '0; wr_value = '0;
        for (int i = 0; i < N; i++) md[i] = 15;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(wr_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_pixel", 64'(pixel), 64'd0);
        chk("rst_in_hud", 64'(in_hud), 64'd0);
        reset = 1'b0;
        scan(200, 1'b1);
        scan(200, 1'b0);

        bin_load(1234);
        probe("d0_b_lit", X0 + 18, Y0 + 10, COL);
        probe("d0_f_dark", X0 + 1, Y0 + 10, 24'h0);
        scan(300, 1'b0);

        bin_load(12000);
        scan(300, 1'b0);

        dwrite(2, 14);
        dwrite(9, 5);
        probe("d2_g_lit", X0 + 2*P + 10, Y0 + M + 2, COL);
        probe("d2_a_dark", X0 + 2*P + 10, Y0 + 1, 24'h0);
        probe("d3_f_kept", X0 + 3*P + 1, Y0 + 10, COL);
        scan(300, 1'b0);

        // Writes arriving while busy are ignored.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_mode = 1'b1; wr_value = VW'(4321);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b1; wr_mode = 1'b1; wr_value = VW'(9999);
        @(posedge clk); #1;
        wr_mode = 1'b0; wr_index = 4'd0; wr_digit = 4'd3;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("busy_ready", 64'(wr_ready), 64'd0);
        wait_ready(low, ov);
        chk("busy_overflow", 64'(ov), 64'd0);
        model_bin(4321);
        scan(300, 1'b0);

        for (int r = 0; r < 6; r++) begin
            bin_load(int'($urandom_range(0, 16383)));
            scan(150, 1'b0);
            for (int w = 0; w < 3; w++) dwrite(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            scan(150, 1'b0);
        end

        // Reset in the middle of a conversion discards it.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_mode = 1'b1; wr_value = VW'(5678);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) md[i] = 15;
        chk("midrst_ready", 64'(wr_ready), 64'd1);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        ov = 0;
        low = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (overflow) ov++;
            if (!wr_ready) low++;
        end
        chk("midrst_no_ovf", 64'(ov), 64'd0);
        chk("midrst_ready_held", 64'(low), 64'd0);
        scan(300, 1'b0);

        bin_load(7);
`ifdef HUD_LZ_BLANK_EN
        probe("lz_d0_f", X0 + 1, Y0 + 10, 24'h0);
`else
        probe("lz_d0_f", X0 + 1, Y0 + 10, COL);
`endif
        probe("lz_d3_b", X0 + 3*P + 18, Y0 + 10, COL);
        scan(300, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
